// File: rtl/multi_port_reg_file.sv
// Two-read / two-write register file with a pending-result scoreboard.
// Optional same-cycle write-to-read forwarding and a hardwired-zero register 0.
module multi_port_reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        ra1,
  input  logic [ADDR_W-1:0]        ra2,
  output logic [DATA_W-1:0]        rd1,
  output logic [DATA_W-1:0]        rd2,
  output logic                     rd1_busy,
  output logic                     rd2_busy,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd0,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  logic                we0_ok, we1_ok, rsv_ok;
  logic [NUM_REGS-1:0] wr0_hot, wr1_hot, rsv_hot;
  logic                fwd1_p1, fwd1_p0, fwd2_p1, fwd2_p0;
  logic [DATA_W-1:0]   stored1, stored2;

  function automatic logic hw_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == ZERO_ADDR);
  endfunction

  function automatic logic [NUM_REGS-1:0] onehot(input logic en, input logic [ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] v;
    v    = {NUM_REGS{1'b0}};
    v[a] = en;
    return v;
  endfunction

  function automatic logic fwd_hit(input logic en, input logic [ADDR_W-1:0] wa,
                                   input logic [ADDR_W-1:0] ra);
    return (BYPASS != 0) && en && (wa == ra);
  endfunction

  // Writes and reservations aimed at a hardwired-zero register are dropped here,
  // so register 0 and its busy bit simply never change.
  assign we0_ok  = we0 && !hw_zero(wa0);
  assign we1_ok  = we1 && !hw_zero(wa1);
  assign rsv_ok  = rsv_en && !hw_zero(rsv_addr);
  assign wr0_hot = onehot(we0_ok, wa0);
  assign wr1_hot = onehot(we1_ok, wa1);
  assign rsv_hot = onehot(rsv_ok, rsv_addr);

  // A reservation beats a same-cycle write: the new producer still owes a result.
  assign busy_d = rsv_hot | (busy_q & ~(wr0_hot | wr1_hot));

  // Next register contents; port 1 wins a same-address collision.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = wr1_hot[i] ? wd1 : (wr0_hot[i] ? wd0 : regs_q[i]);
    end
  end

  // State update with synchronous reset overriding any write or reservation.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= {NUM_REGS{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= ZERO_DATA;
      end
    end else begin
      busy_q <= busy_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign fwd1_p1 = fwd_hit(we1_ok, wa1, ra1);
  assign fwd1_p0 = fwd_hit(we0_ok, wa0, ra1);
  assign fwd2_p1 = fwd_hit(we1_ok, wa1, ra2);
  assign fwd2_p0 = fwd_hit(we0_ok, wa0, ra2);

  assign stored1 = hw_zero(ra1) ? ZERO_DATA : regs_q[ra1];
  assign stored2 = hw_zero(ra2) ? ZERO_DATA : regs_q[ra2];

  // A forwarded read delivers the pending value, so it is no longer busy.
  assign rd1      = fwd1_p1 ? wd1 : (fwd1_p0 ? wd0 : stored1);
  assign rd2      = fwd2_p1 ? wd1 : (fwd2_p0 ? wd0 : stored2);
  assign rd1_busy = (fwd1_p1 || fwd1_p0) ? 1'b0 : busy_q[ra1];
  assign rd2_busy = (fwd2_p1 || fwd2_p0) ? 1'b0 : busy_q[ra2];
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_multi_port_reg_file.sv
// Directed, table-driven bench: default configuration in a vector table, plus
// hand sequences comparing it against a BYPASS=0 / ZERO_REG=0 instance.
module tb_multi_port_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra1, ra2, wa0, wa1, rsv_addr;
  logic        we0, we1, rsv_en;
  logic [31:0] wd0, wd1;

  logic [31:0] rd1, rd2, rd1_a, rd2_a, busy_vec, busy_vec_a;
  logic        rd1_busy, rd2_busy, rd1_busy_a, rd2_busy_a;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multi_port_reg_file dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .rd1_busy(rd1_busy), .rd2_busy(rd2_busy), .we0(we0), .we1(we1),
    .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .busy_vec(busy_vec)
  );

  multi_port_reg_file #(.BYPASS(0), .ZERO_REG(0)) dut_alt (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
    .rd1_busy(rd1_busy_a), .rd2_busy(rd2_busy_a), .we0(we0), .we1(we1),
    .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .busy_vec(busy_vec_a)
  );

  typedef struct packed {
    logic        rst;
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_b1;
    logic        e_b2;
    logic [31:0] e_bv;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; we0 = 1'b0; we1 = 1'b0; rsv_en = 1'b0;
    wa0 = 5'd0; wa1 = 5'd0; wd0 = 32'h0; wd1 = 32'h0; rsv_addr = 5'd0;
  endtask

  initial begin
    // rst we0 wa0 wd0 | we1 wa1 wd1 | rsv addr | ra1 ra2 | e_rd1 e_rd2 e_b1 e_b2 e_bv
    tbl[0]  = '{1'b0, 1'b1,5'd4,32'h11, 1'b1,5'd4,32'h22, 1'b0,5'd0, 5'd4,5'd3,
                32'h22,32'h0,1'b0,1'b0,32'h0};
    tbl[1]  = '{1'b0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd4,5'd0,
                32'h22,32'h0,1'b0,1'b0,32'h0};
    tbl[2]  = '{1'b0, 1'b1,5'd0,32'hFFFF_FFFF, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd0,5'd4,
                32'h0,32'h22,1'b0,1'b0,32'h0};
    tbl[3]  = '{1'b0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd7, 5'd0,5'd7,
                32'h0,32'h0,1'b0,1'b0,32'h0};
    tbl[4]  = '{1'b0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd7,5'd4,
                32'h0,32'h22,1'b1,1'b0,32'h80};
    tbl[5]  = '{1'b0, 1'b0,5'd0,32'h0, 1'b1,5'd7,32'h55, 1'b0,5'd0, 5'd7,5'd2,
                32'h55,32'h0,1'b0,1'b0,32'h80};
    tbl[6]  = '{1'b0, 1'b1,5'd9,32'h99, 1'b0,5'd0,32'h0, 1'b1,5'd9, 5'd7,5'd9,
                32'h55,32'h99,1'b0,1'b0,32'h0};
    tbl[7]  = '{1'b0, 1'b1,5'd2,32'h1234, 1'b1,5'd5,32'h5678, 1'b0,5'd0, 5'd9,5'd0,
                32'h99,32'h0,1'b1,1'b0,32'h200};
    tbl[8]  = '{1'b0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd2,5'd5,
                32'h1234,32'h5678,1'b0,1'b0,32'h200};
    tbl[9]  = '{1'b0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd0, 5'd9,5'd0,
                32'h99,32'h0,1'b1,1'b0,32'h200};
    tbl[10] = '{1'b0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd9, 5'd0,5'd9,
                32'h0,32'h99,1'b0,1'b1,32'h200};
    tbl[11] = '{1'b0, 1'b0,5'd0,32'h0, 1'b1,5'd3,32'h33, 1'b0,5'd0, 5'd9,5'd3,
                32'h99,32'h33,1'b1,1'b0,32'h200};
    tbl[12] = '{1'b0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd31, 5'd3,5'd9,
                32'h33,32'h99,1'b0,1'b1,32'h200};
    tbl[13] = '{1'b0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd31,5'd5,
                32'h0,32'h5678,1'b1,1'b0,32'h8000_0200};
    tbl[14] = '{1'b1, 1'b1,5'd5,32'hAAAA, 1'b0,5'd0,32'h0, 1'b1,5'd12, 5'd31,5'd2,
                32'h0,32'h1234,1'b1,1'b0,32'h8000_0200};
    tbl[15] = '{1'b0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd5,5'd31,
                32'h0,32'h0,1'b0,1'b0,32'h0};
    tbl[16] = '{1'b0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd12,5'd2,
                32'h0,32'h0,1'b0,1'b0,32'h0};
    tbl[17] = '{1'b0, 1'b1,5'd6,32'h66, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd6,5'd6,
                32'h66,32'h66,1'b0,1'b0,32'h0};

    // Reset, with a write to R3 on the last reset cycle that must be discarded.
    idle(); ra1 = 5'd0; ra2 = 5'd0; rst = 1'b1;
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hAA;
    @(negedge clk);
    idle();
    #1;
    for (int a = 0; a < 32; a++) begin
      ra1 = a[4:0]; ra2 = 5'd31 - a[4:0];
      #1;
      chk($sformatf("reset rd1 a%0d", a), {32'h0, rd1}, 64'h0);
      chk($sformatf("reset rd2 a%0d", a), {32'h0, rd2}, 64'h0);
      chk($sformatf("reset alt rd1 a%0d", a), {32'h0, rd1_a}, 64'h0);
      chk($sformatf("reset busy a%0d", a), {62'h0, rd1_busy, rd2_busy}, 64'h0);
    end
    chk("reset busy_vec", {32'h0, busy_vec}, 64'h0);
    chk("reset alt busy_vec", {32'h0, busy_vec_a}, 64'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
      we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
      rsv_en = tbl[i].rsv_en; rsv_addr = tbl[i].rsv_addr;
      ra1 = tbl[i].ra1; ra2 = tbl[i].ra2;
      #2;
      chk($sformatf("v%0d rd1", i), {32'h0, rd1}, {32'h0, tbl[i].e_rd1});
      chk($sformatf("v%0d rd2", i), {32'h0, rd2}, {32'h0, tbl[i].e_rd2});
      chk($sformatf("v%0d rd1_busy", i), {63'h0, rd1_busy}, {63'h0, tbl[i].e_b1});
      chk($sformatf("v%0d rd2_busy", i), {63'h0, rd2_busy}, {63'h0, tbl[i].e_b2});
      chk($sformatf("v%0d busy_vec", i), {32'h0, busy_vec}, {32'h0, tbl[i].e_bv});
    end

    // Hand sequence: BYPASS=0 / ZERO_REG=0 instance against the default one.
    @(negedge clk);
    idle(); rst = 1'b1;
    @(negedge clk);
    idle(); we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h77;
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h11; we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h22; ra1 = 5'd4;
    #2;
    chk("dual wr fwd rd1", {32'h0, rd1}, 64'h22);
    chk("dual wr nofwd rd1", {32'h0, rd1_a}, 64'h77);
    @(negedge clk);
    idle(); ra1 = 5'd4;
    #2;
    chk("dual wr commit", {32'h0, rd1}, 64'h22);
    chk("dual wr commit alt", {32'h0, rd1_a}, 64'h22);
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF; ra1 = 5'd0;
    #2;
    chk("r0 wr same cycle", {32'h0, rd1}, 64'h0);
    chk("r0 wr same cycle alt", {32'h0, rd1_a}, 64'h0);
    @(negedge clk);
    idle(); ra1 = 5'd0;
    #2;
    chk("r0 hardwired", {32'h0, rd1}, 64'h0);
    chk("r0 ordinary alt", {32'h0, rd1_a}, 64'hFFFF_FFFF);
    rsv_en = 1'b1; rsv_addr = 5'd7;
    @(negedge clk);
    idle(); we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h55; ra1 = 5'd7;
    #2;
    chk("rsv7 fwd rd1", {32'h0, rd1}, 64'h55);
    chk("rsv7 fwd busy", {63'h0, rd1_busy}, 64'h0);
    chk("rsv7 nofwd rd1 alt", {32'h0, rd1_a}, 64'h0);
    chk("rsv7 nofwd busy alt", {63'h0, rd1_busy_a}, 64'h1);
    @(negedge clk);
    idle(); ra1 = 5'd7;
    #2;
    chk("rsv7 cleared", {32'h0, busy_vec}, 64'h0);
    chk("rsv7 cleared alt", {32'h0, busy_vec_a}, 64'h0);
    chk("r7 alt", {32'h0, rd1_a}, 64'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
